// File: rtl/fnv_lane_reduce_pkg.sv
// rtl/fnv_lane_reduce_pkg.sv - shared FNV constants, mix functions and reduce FSM states
package FnvPkg;

   localparam logic [31:0] FNV_PRIME_C  = 32'h01000193;
   localparam logic [31:0] FNV_OFFSET_C = 32'h811c9dc5;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } fnv_reduce_state_t;

   // Products are truncated to 32 bits by the assignment width.
   function automatic logic [31:0] fnv1(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] p = FNV_PRIME_C);
      logic [31:0] w_prod;
      w_prod = x * p;
      return w_prod ^ y;
   endfunction

   function automatic logic [31:0] fnv1a(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] p = FNV_PRIME_C);
      logic [31:0] w_mix;
      w_mix = x ^ y;
      return w_mix * p;
   endfunction

endpackage

// File: rtl/fnv_lane_reduce_step.sv
// rtl/fnv_lane_reduce_step.sv - combinational FNV step, shared by the map and reduce stages
module fnv_step
   import FnvPkg::*;
#(
   parameter bit          USE_FNV1A = 1'b1,
   parameter logic [31:0] FNV_PRIME = FNV_PRIME_C
) (
   input  logic [31:0] i_h,
   input  logic [31:0] i_d,
   output logic [31:0] o_h
);

   generate
      if (USE_FNV1A) begin : g_fnv1a
         assign o_h = fnv1a(i_h, i_d, FNV_PRIME);
      end else begin : g_fnv1
         assign o_h = fnv1(i_h, i_d, FNV_PRIME);
      end
   endgenerate

endmodule

// File: rtl/fnv_lane_reduce.sv
// rtl/fnv_lane_reduce.sv - folds NUM_WORDS map-stage words into one 32-bit lane digest
module fnv_lane_reduce
   import FnvPkg::*;
#(
   parameter int          NUM_WORDS  = 16,
   parameter logic [31:0] FNV_OFFSET = FNV_OFFSET_C,
   parameter logic [31:0] FNV_PRIME  = FNV_PRIME_C,
   parameter bit          USE_FNV1A  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_hash,
   output logic [15:0] word_cnt
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

   fnv_reduce_state_t r_state;
   logic [31:0]       r_hash;
   logic [31:0]       r_out_hash;
   logic [15:0]       r_word_cnt;
   logic              r_out_valid;
   logic              r_armed;
   logic [31:0]       w_next_hash;
   logic              w_accept;

   fnv_step #(
      .USE_FNV1A(USE_FNV1A),
      .FNV_PRIME(FNV_PRIME)
   ) u_step (
      .i_h(r_hash),
      .i_d(in_data),
      .o_h(w_next_hash)
   );

   // r_armed keeps in_ready low until the first clock after reset release.
   assign in_ready  = r_armed & (r_state == ACCUM);
   assign w_accept  = in_valid & in_ready;
   assign out_valid = r_out_valid;
   assign out_hash  = r_out_hash;
   assign word_cnt  = r_word_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACCUM;
         r_hash      <= FNV_OFFSET;
         r_out_hash  <= '0;
         r_word_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (flush) begin
            r_state     <= ACCUM;
            r_hash      <= FNV_OFFSET;
            r_word_cnt  <= '0;
            r_out_valid <= 1'b0;
         end else if (r_state == ACCUM) begin
            if (w_accept) begin
               r_hash <= w_next_hash;
               if (r_word_cnt == LAST_IDX) begin
                  r_state     <= EMIT;
                  r_out_hash  <= w_next_hash;
                  r_out_valid <= 1'b1;
                  r_word_cnt  <= '0;
               end else begin
                  r_word_cnt <= r_word_cnt + 16'd1;
               end
            end
         end else if (out_ready) begin
            r_state     <= ACCUM;
            r_hash      <= FNV_OFFSET;
            r_out_valid <= 1'b0;
         end
      end
   end

   a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (r_out_valid && !out_ready && !flush) |=> (r_out_valid && $stable(r_out_hash)));

   a_no_ready_in_emit: assert property (@(posedge clk) disable iff (!rst_n)
      r_out_valid |-> !in_ready);

endmodule
